// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EXE and WB.
//   Takes over instructions whose data_sram request EXE already issued, waits for the matching
//   data_ok, then extracts and extends load data. It also forwards its result to ID, raises the
//   exception flush toward EXE, and drops responses that belong to instructions cancelled by an
//   exception or ertn.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   exe_to_mem_valid/exe_*      incoming instruction bundle from EXE
//   exe_req_sent                EXE already issued the data_sram request for the incoming inst
//   mem_allowin                 MEM accepts an instruction this cycle
//   data_sram_data_ok/_rdata    in-order data_sram response
//   wb_allowin                  WB accepts
//   cancel_exc_ertn             flush from WB
//   mem_to_wb_valid, mem_*      outgoing bundle to WB
//   mem_fwd_all                 {csr_wr, csr_wr_num, res_from_mem, rf_all, final_result} to ID
//   mem_load_busy               valid load still waiting for its data
//   mem_exc_flush               valid instruction carries an exception
module mem_stage #(
  parameter int DISCARD_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exe_to_mem_valid,
  output logic        mem_allowin,
  input  logic        exe_req_sent,
  input  logic [31:0] exe_pc,
  input  logic [31:0] exe_result,
  input  logic        exe_res_from_mem,
  input  logic [7:0]  exe_mem_all,
  input  logic [5:0]  exe_rf_all,
  input  logic [6:0]  exe_exc_rf,
  input  logic [78:0] exe_csr_rf,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        wb_allowin,
  input  logic        cancel_exc_ertn,
  output logic        mem_to_wb_valid,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_final_result,
  output logic [5:0]  mem_rf_all,
  output logic [6:0]  mem_exc_rf,
  output logic [78:0] mem_csr_rf,
  output logic [53:0] mem_fwd_all,
  output logic        mem_load_busy,
  output logic        mem_exc_flush
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  localparam logic [DISCARD_W:0] CNT_MAX = (DISCARD_W+1)'((1 << DISCARD_W) - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_pc;
  logic [31:0]          r_result;
  logic                 r_res_from_mem;
  logic [3:0]           r_ld_ctl;       // {ld_b, ld_h, ld_w, ld_se}
  logic [5:0]           r_rf_all;
  logic [6:0]           r_exc_rf;
  logic [78:0]          r_csr_rf;
  logic [31:0]          r_rdata_buf;
  logic [DISCARD_W-1:0] r_discard_cnt;

  logic                 w_valid;
  logic                 w_disc_zero;
  logic                 w_data_take;
  logic                 w_drop;
  logic                 w_ready_go;
  logic                 w_capture;
  logic                 w_inc_wait;
  logic                 w_inc_exe;
  logic [DISCARD_W:0]   w_cnt_sum;
  logic [31:0]          w_ld_word;
  logic [31:0]          w_load_data;
  logic [31:0]          w_final;
  logic                 w_unused_st;

  // Store-type and ld_w bits are not needed here: the word is the default load view.
  assign w_unused_st = ^{exe_mem_all[7], exe_mem_all[4], exe_mem_all[2:0], r_ld_ctl[1]};

  // Select the addressed byte/half of the response word and extend it.
  function automatic logic [31:0] ext_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic ld_b, input logic ld_h, input logic ld_se);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    if (ld_b)      res = {{24{ld_se & b[7]}}, b};
    else if (ld_h) res = {{16{ld_se & h[15]}}, h};
    else           res = word;
    return res;
  endfunction

  assign w_valid     = (r_state != S_EMPTY);
  assign w_disc_zero = (r_discard_cnt == '0);
  // A response is ours only when no abandoned responses are still ahead of it.
  assign w_data_take = (r_state == S_WAIT) & data_sram_data_ok & w_disc_zero;
  assign w_drop      = data_sram_data_ok & ~w_disc_zero;
  assign w_ready_go  = (r_state == S_READY) | w_data_take;
  assign mem_allowin = ~w_valid | (w_ready_go & wb_allowin);
  assign w_capture   = exe_to_mem_valid & mem_allowin & ~cancel_exc_ertn;

  // On a flush, every request already issued but not yet answered becomes an orphan response.
  assign w_inc_wait = cancel_exc_ertn & (r_state == S_WAIT) & ~w_data_take;
  assign w_inc_exe  = cancel_exc_ertn & exe_req_sent & exe_to_mem_valid;
  assign w_cnt_sum  = {1'b0, r_discard_cnt}
                    + {{DISCARD_W{1'b0}}, w_inc_wait}
                    + {{DISCARD_W{1'b0}}, w_inc_exe}
                    - {{DISCARD_W{1'b0}}, w_drop};

  // Bypass the response in its arrival cycle so the load completes without an extra cycle.
  assign w_ld_word   = w_data_take ? data_sram_rdata : r_rdata_buf;
  assign w_load_data = ext_load(w_ld_word, r_result[1:0], r_ld_ctl[3], r_ld_ctl[2], r_ld_ctl[0]);
  assign w_final     = r_res_from_mem ? w_load_data : r_result;

  assign mem_to_wb_valid  = w_valid & w_ready_go;
  assign mem_pc           = r_pc;
  assign mem_final_result = w_final;
  assign mem_rf_all       = r_rf_all;
  assign mem_exc_rf       = r_exc_rf;
  assign mem_csr_rf       = r_csr_rf;
  assign mem_fwd_all      = w_valid ? {r_csr_rf[77], r_csr_rf[76:63], r_res_from_mem, r_rf_all, w_final}
                                    : 54'd0;
  assign mem_load_busy    = (r_state == S_WAIT) & r_res_from_mem & ~w_data_take;
  assign mem_exc_flush    = w_valid & (|r_exc_rf);

  always_comb begin
    w_state_nxt = r_state;
    if (cancel_exc_ertn)             w_state_nxt = S_EMPTY;
    else if (w_capture)              w_state_nxt = exe_req_sent ? S_WAIT : S_READY;
    else if (w_ready_go & wb_allowin) w_state_nxt = S_EMPTY;
    else if (w_data_take)            w_state_nxt = S_READY;
  end

  // p0: state, discard counter and payload registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_EMPTY;
      r_discard_cnt  <= '0;
      r_pc           <= '0;
      r_result       <= '0;
      r_res_from_mem <= 1'b0;
      r_ld_ctl       <= '0;
      r_rf_all       <= '0;
      r_exc_rf       <= '0;
      r_csr_rf       <= '0;
      r_rdata_buf    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_discard_cnt <= w_cnt_sum[DISCARD_W-1:0];
      if (w_capture) begin
        r_pc           <= exe_pc;
        r_result       <= exe_result;
        r_res_from_mem <= exe_res_from_mem;
        r_ld_ctl       <= exe_mem_all[6:3];
        r_rf_all       <= exe_rf_all;
        r_exc_rf       <= exe_exc_rf;
        r_csr_rf       <= exe_csr_rf;
      end
      if (w_data_take) r_rdata_buf <= data_sram_rdata;
    end
  end

  // More orphan responses than the counter can hold would corrupt response matching.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (w_cnt_sum <= CNT_MAX);
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        exe_to_mem_valid;
  logic        mem_allowin;
  logic        exe_req_sent;
  logic [31:0] exe_pc;
  logic [31:0] exe_result;
  logic        exe_res_from_mem;
  logic [7:0]  exe_mem_all;
  logic [5:0]  exe_rf_all;
  logic [6:0]  exe_exc_rf;
  logic [78:0] exe_csr_rf;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        wb_allowin;
  logic        cancel_exc_ertn;
  logic        mem_to_wb_valid;
  logic [31:0] mem_pc;
  logic [31:0] mem_final_result;
  logic [5:0]  mem_rf_all;
  logic [6:0]  mem_exc_rf;
  logic [78:0] mem_csr_rf;
  logic [53:0] mem_fwd_all;
  logic        mem_load_busy;
  logic        mem_exc_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.DISCARD_W(2)) dut (
    .clk(clk), .reset(reset),
    .exe_to_mem_valid(exe_to_mem_valid), .mem_allowin(mem_allowin),
    .exe_req_sent(exe_req_sent), .exe_pc(exe_pc), .exe_result(exe_result),
    .exe_res_from_mem(exe_res_from_mem), .exe_mem_all(exe_mem_all),
    .exe_rf_all(exe_rf_all), .exe_exc_rf(exe_exc_rf), .exe_csr_rf(exe_csr_rf),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .wb_allowin(wb_allowin), .cancel_exc_ertn(cancel_exc_ertn),
    .mem_to_wb_valid(mem_to_wb_valid), .mem_pc(mem_pc),
    .mem_final_result(mem_final_result), .mem_rf_all(mem_rf_all),
    .mem_exc_rf(mem_exc_rf), .mem_csr_rf(mem_csr_rf), .mem_fwd_all(mem_fwd_all),
    .mem_load_busy(mem_load_busy), .mem_exc_flush(mem_exc_flush)
  );

  task automatic chk(input string tag, input logic [78:0] obs, input logic [78:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic exe_idle();
    exe_to_mem_valid = 1'b0;
    exe_req_sent     = 1'b0;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] res, input logic rfm,
                         input logic [7:0] mall, input logic [5:0] rf, input logic [6:0] exc,
                         input logic [78:0] csr, input logic req);
    exe_to_mem_valid = 1'b1;
    exe_pc           = pc;
    exe_result       = res;
    exe_res_from_mem = rfm;
    exe_mem_all      = mall;
    exe_rf_all       = rf;
    exe_exc_rf       = exc;
    exe_csr_rf       = csr;
    exe_req_sent     = req;
  endtask

  // Load whose response arrives in the cycle right after capture.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [7:0] mall,
                         input logic [31:0] rdata, input logic [31:0] exp);
    present(32'h1c00_0100, addr, 1'b1, mall, 6'h21, 7'h0, 79'h0, 1'b1);
    tick();
    exe_idle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    settle();
    chk({tag, "_valid"}, mem_to_wb_valid, 1'b1);
    chk({tag, "_data"}, mem_final_result, exp);
    tick();
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    exe_idle();
    exe_pc = '0; exe_result = '0; exe_res_from_mem = 1'b0; exe_mem_all = '0;
    exe_rf_all = '0; exe_exc_rf = '0; exe_csr_rf = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    wb_allowin = 1'b1; cancel_exc_ertn = 1'b0;
    tick(); tick();
    reset = 1'b0;
    settle();

    // Reset state
    chk("rst_valid", mem_to_wb_valid, 1'b0);
    chk("rst_result", mem_final_result, 32'h0);
    chk("rst_fwd", mem_fwd_all, 54'h0);
    chk("rst_busy", mem_load_busy, 1'b0);
    chk("rst_flush", mem_exc_flush, 1'b0);
    chk("rst_allowin", mem_allowin, 1'b1);

    // ld.w at 0x1000, response three cycles after capture
    present(32'h1c00_0000, 32'h0000_1000, 1'b1, 8'h10, 6'h24, 7'h0, 79'h0, 1'b1);
    settle();
    chk("t1_allowin", mem_allowin, 1'b1);
    tick();
    exe_idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t1_busy", mem_load_busy, 1'b1);
      chk("t1_wait_valid", mem_to_wb_valid, 1'b0);
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    settle();
    chk("t1_valid", mem_to_wb_valid, 1'b1);
    chk("t1_data", mem_final_result, 32'hDEAD_BEEF);
    chk("t1_pc", mem_pc, 32'h1c00_0000);
    chk("t1_fwd", mem_fwd_all, {1'b0, 14'h0, 1'b1, 6'h24, 32'hDEAD_BEEF});
    tick();
    data_sram_data_ok = 1'b0;
    settle();
    chk("t1_done_valid", mem_to_wb_valid, 1'b0);
    chk("t1_done_fwd", mem_fwd_all, 54'h0);

    // Byte/half extraction and extension
    do_load("t2_ldb_se", 32'h0000_1003, 8'h48, 32'h8011_2233, 32'hFFFF_FF80);
    do_load("t2_ldhu", 32'h0000_1002, 8'h20, 32'h8011_2233, 32'h0000_8011);
    do_load("t2_ldh_se", 32'h0000_1002, 8'h28, 32'h8011_2233, 32'hFFFF_8011);
    do_load("t2_ldbu", 32'h0000_1001, 8'h40, 32'h8011_2233, 32'h0000_0022);

    // Response arrives while WB stalls; buffered value must survive
    present(32'h1c00_0200, 32'h0000_2000, 1'b1, 8'h10, 6'h22, 7'h0, 79'h0, 1'b1);
    tick();
    exe_idle();
    wb_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1234_5678;
    settle();
    chk("t3_ok_valid", mem_to_wb_valid, 1'b1);
    chk("t3_ok_allowin", mem_allowin, 1'b0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hFFFF_FFFF;
    settle();
    chk("t3_hold1_valid", mem_to_wb_valid, 1'b1);
    chk("t3_hold1_data", mem_final_result, 32'h1234_5678);
    tick();
    wb_allowin = 1'b1;
    settle();
    chk("t3_go_valid", mem_to_wb_valid, 1'b1);
    chk("t3_go_data", mem_final_result, 32'h1234_5678);
    tick();
    settle();
    chk("t3_single_xfer", mem_to_wb_valid, 1'b0);

    // Store waits for its write response; result is the address
    present(32'h1c00_0300, 32'h0000_4004, 1'b0, 8'h81, 6'h00, 7'h0, 79'h0, 1'b1);
    tick();
    exe_idle();
    settle();
    chk("st_wait_valid", mem_to_wb_valid, 1'b0);
    chk("st_busy", mem_load_busy, 1'b0);
    chk("st_addr", mem_final_result, 32'h0000_4004);
    data_sram_data_ok = 1'b1;
    settle();
    chk("st_ok_valid", mem_to_wb_valid, 1'b1);
    tick();
    data_sram_data_ok = 1'b0;

    // Flush while waiting; the orphan response must be dropped
    present(32'h1c00_0400, 32'h0000_2800, 1'b1, 8'h10, 6'h23, 7'h0, 79'h0, 1'b1);
    tick();
    exe_idle();
    cancel_exc_ertn = 1'b1;
    settle();
    chk("t4_cancel_valid", mem_to_wb_valid, 1'b0);
    tick();
    cancel_exc_ertn = 1'b0;
    settle();
    chk("t4_cnt1", dut.r_discard_cnt, 2'd1);
    chk("t4_empty_fwd", mem_fwd_all, 54'h0);
    present(32'h1c00_0500, 32'h0000_3000, 1'b1, 8'h10, 6'h25, 7'h0, 79'h0, 1'b1);
    settle();
    chk("t4_allowin", mem_allowin, 1'b1);
    tick();
    exe_idle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_AAAA;
    settle();
    chk("t4_drop_valid", mem_to_wb_valid, 1'b0);
    chk("t4_drop_busy", mem_load_busy, 1'b1);
    tick();
    data_sram_data_ok = 1'b0;
    settle();
    chk("t4_cnt0", dut.r_discard_cnt, 2'd0);
    chk("t4_still_wait", mem_to_wb_valid, 1'b0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_0005;
    settle();
    chk("t4_valid", mem_to_wb_valid, 1'b1);
    chk("t4_data", mem_final_result, 32'h0000_0005);
    tick();
    data_sram_data_ok = 1'b0;
    settle();
    chk("t4_done", mem_to_wb_valid, 1'b0);

    // ALE instruction without a request goes straight to READY
    wb_allowin = 1'b0;
    present(32'h1c00_0600, 32'h0000_1001, 1'b0, 8'h10, 6'h00, 7'h10,
            {1'b0, 1'b1, 14'h0006, 63'h0}, 1'b0);
    tick();
    exe_idle();
    settle();
    chk("t5_flush", mem_exc_flush, 1'b1);
    chk("t5_valid", mem_to_wb_valid, 1'b1);
    chk("t5_exc", mem_exc_rf, 7'h10);
    chk("t5_fwd", mem_fwd_all, {1'b1, 14'h0006, 1'b0, 6'h00, 32'h0000_1001});
    tick();
    settle();
    chk("t5_flush_hold", mem_exc_flush, 1'b1);
    wb_allowin = 1'b1;
    tick();
    settle();
    chk("t5_flush_gone", mem_exc_flush, 1'b0);

    // Reset in the middle of a wait clears everything
    present(32'h1c00_0700, 32'h0000_5000, 1'b1, 8'h10, 6'h26, 7'h0,
            {1'b1, 1'b1, 14'h0123, 63'h1}, 1'b1);
    tick();
    exe_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("t6_valid", mem_to_wb_valid, 1'b0);
    chk("t6_cnt", dut.r_discard_cnt, 2'd0);
    chk("t6_pc", mem_pc, 32'h0);
    chk("t6_result", mem_final_result, 32'h0);
    chk("t6_rf", mem_rf_all, 6'h0);
    chk("t6_csr", mem_csr_rf, 79'h0);
    chk("t6_fwd", mem_fwd_all, 54'h0);
    chk("t6_busy", mem_load_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
